// File: rtl/meas_pkg.sv
// rtl/meas_pkg.sv - shared states, ASCII constants and digit encoding for meas_scheduler
package meas_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_START = 2'd1;
   localparam state_t S_WAIT  = 2'd2;
   localparam state_t S_SEND  = 2'd3;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_DASH  = 8'h2D;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   localparam int LINE_LEN = 6;

   // Non-decimal nibbles are shown as '?' so a corrupt result is still visible on the line.
   function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
      if (digit > 4'd9)
         return ASCII_QMARK;
      return ASCII_ZERO + {4'd0, digit};
   endfunction

endpackage

// File: rtl/period_timer.sv
// rtl/period_timer.sv - enable-gated free-running counter producing a periodic tick
module period_timer #(
   parameter int PERIOD_CYCLES = 6_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int CW = $clog2(PERIOD_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

   logic [CW-1:0] cnt;

   assign tick = enable && (cnt == LAST);

   // Dropping enable restarts the period from zero.
   always_ff @(posedge clk) begin
      if (rst || !enable)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/meas_scheduler.sv
// rtl/meas_scheduler.sv - triggers ranging measurements and streams each result as an ASCII line
module meas_scheduler
   import meas_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PERIOD_CYCLES  = 6_000_000,
   parameter int TIMEOUT_CYCLES = 4_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  go_btn,
   input  logic                  auto_en,
   output logic                  meas_start,
   input  logic                  meas_done,
   input  logic [15:0]           meas_bcd,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0] IDX_LAST = 3'(LINE_LEN - 1);

   state_t        state;
   logic          go_q;
   logic          pending;
   logic [TW-1:0] tcnt;
   logic [2:0]    idx;
   logic [15:0]   res;
   logic          err;
   logic          tick;
   logic          btn_rise;
   logic          req;
   logic          xfer;
   logic [7:0]    line_byte;

   period_timer #(
      .PERIOD_CYCLES(PERIOD_CYCLES)
   ) u_period_timer (
      .clk   (clk),
      .rst   (rst),
      .enable(auto_en),
      .tick  (tick)
   );

   assign btn_rise    = go_btn & ~go_q;
   assign req         = btn_rise | tick;
   assign xfer        = valid_out & ready_in;
   assign busy        = (state != S_IDLE);
   assign meas_start  = (state == S_START);
   assign timeout_err = (state == S_WAIT) && !meas_done && (tcnt == T_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         go_q      <= 1'b0;
         pending   <= 1'b0;
         tcnt      <= '0;
         idx       <= '0;
         res       <= '0;
         err       <= 1'b0;
         valid_out <= 1'b0;
      end else begin
         go_q <= go_btn;
         // Only one request is remembered while busy; further ones are dropped.
         if (busy && req)
            pending <= 1'b1;
         case (state)
            S_IDLE: begin
               if (req || pending) begin
                  state   <= S_START;
                  pending <= 1'b0;
               end
            end
            S_START: begin
               tcnt  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (meas_done) begin
                  res       <= meas_bcd;
                  err       <= 1'b0;
                  idx       <= '0;
                  valid_out <= 1'b1;
                  state     <= S_SEND;
               end else if (tcnt == T_LAST) begin
                  err       <= 1'b1;
                  idx       <= '0;
                  valid_out <= 1'b1;
                  state     <= S_SEND;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            S_SEND: begin
               if (xfer) begin
                  if (idx == IDX_LAST) begin
                     idx       <= '0;
                     valid_out <= 1'b0;
                     state     <= S_IDLE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: begin
               valid_out <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      line_byte = ASCII_LF;
      case (idx)
         3'd0:    line_byte = err ? ASCII_DASH : digit_to_ascii(res[15:12]);
         3'd1:    line_byte = err ? ASCII_DASH : digit_to_ascii(res[11:8]);
         3'd2:    line_byte = err ? ASCII_DASH : digit_to_ascii(res[7:4]);
         3'd3:    line_byte = err ? ASCII_DASH : digit_to_ascii(res[3:0]);
         3'd4:    line_byte = ASCII_CR;
         default: line_byte = ASCII_LF;
      endcase
   end

   // Driven from registered idx/res/err only, so the byte cannot change under backpressure.
   assign data_out = valid_out ? DATA_WIDTH'(line_byte) : '0;

endmodule

// File: doc/meas_scheduler.md
Name: meas_scheduler

Overview:
Sequences the ultrasonic ranging datapath. It issues measurement starts to the sensor controller, either from the push-button or from a periodic auto-trigger. It waits for the BCD result with a timeout, then streams the result as an ASCII line over the UART byte handshake. It sits between the top-level button input, the sensor/BCD pair and uart_tx, and owns the UART byte stream.

Parameters:
DATA_WIDTH, 8, UART byte width; fixed at 8, since ASCII encoding depends on it
PERIOD_CYCLES, 6_000_000, auto-trigger period in clk cycles (60 ms at 100 MHz); must be >= 2
TIMEOUT_CYCLES, 4_000_000, maximum wait for meas_done after meas_start; must be >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
go_btn  in  1  manual trigger level, already debounced; rising edge requests one measurement
auto_en  in  1  level; 1 = periodic auto-trigger enabled
meas_start  out  1  one-cycle start pulse to the sensor controller
meas_done  in  1  one-cycle pulse; meas_bcd is valid in the same cycle
meas_bcd  in  16  four BCD digits, [15:12] most significant
data_out  out  DATA_WIDTH  byte to uart_tx
valid_out  out  1  byte valid
ready_in  in  1  uart_tx ready
busy  out  1  1 in any state other than IDLE
timeout_err  out  1  one-cycle pulse when a measurement times out

Behaviour:
- Reset: all outputs are 0, state is IDLE, counters are 0, pending is 0, go_btn history register is 0. Reset applies on the same edge in every state, including mid-SEND: valid_out drops and the partial line is abandoned.
- Requests:
  - btn_rise = go_btn & ~go_q, where go_q is go_btn registered.
  - tick = period counter at PERIOD_CYCLES-1 while auto_en=1.
  - The period counter counts only while auto_en=1, wraps to 0 after a tick, and clears when auto_en=0.
- FSM states:
  - IDLE: if btn_rise, tick or pending, go to START and clear pending.
  - START: meas_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT:
    - If meas_done, latch meas_bcd into res, clear the err flag, go to SEND.
    - Else, when the timeout counter reaches TIMEOUT_CYCLES-1, pulse timeout_err, set the err flag, go to SEND.
    - meas_done wins if it coincides with the timeout terminal count.
  - SEND: emits 6 bytes with idx 0..5.
    - Normal line: ASCII of res digits, MSD first, then 0x0D, 0x0A.
    - Any digit > 9 is sent as 0x3F ('?').
    - Err line: 0x2D x4, 0x0D, 0x0A.
    - Transfer occurs when valid_out & ready_in; idx advances on the transfer.
    - After the transfer of idx 5, go to IDLE.
- Handshake:
  - valid_out is registered and high throughout SEND.
  - data_out is stable while valid_out=1 and ready_in=0.
  - There is no bubble between bytes; the next byte is presented on the edge after a transfer.
- Latency:
  - btn_rise sampled in cycle n gives meas_start=1 in cycle n+1.
  - meas_done in cycle m gives the first byte valid in cycle m+1.
- Pending:
  - A btn_rise or tick while busy=1 sets pending, which holds a single request; extra requests are dropped.
  - A request in the same cycle the FSM returns to IDLE is captured as pending.
- meas_done outside WAIT is ignored.
- A change on meas_bcd outside the meas_done cycle has no effect.

Decomposition:
- Package meas_pkg: state enum (IDLE, START, WAIT, SEND), ASCII constants (ZERO 0x30, DASH 0x2D, QMARK 0x3F, CR 0x0D, LF 0x0A), LINE_LEN=6.
- Sub-module period_timer: the auto_en-gated counter with a tick output, parameterised by PERIOD_CYCLES.
- The byte mux (idx to ASCII) stays inline.

Test Plan:
1. Button trigger: go_btn 0→1 at cycle 10; meas_done with meas_bcd=16'h0123 at cycle 50; ready_in=1 → meas_start high at cycle 11 only; bytes 0x30,0x31,0x32,0x33,0x0D,0x0A in cycles 51–56; busy=0 from cycle 57.
2. Backpressure: as test 1 with ready_in toggling 1,0,0,1 → each byte held stable while ready_in=0; exactly 6 transfers, in order.
3. Timeout: TIMEOUT_CYCLES=20, no meas_done → timeout_err pulses once 20 cycles after START; line 0x2D x4, 0x0D, 0x0A.
4. Auto/pending: PERIOD_CYCLES=30, auto_en=1, meas_done delayed past one period → exactly one queued measurement follows the first line; no third start before the next tick.
5. Invalid digit: meas_bcd=16'h9A05 → bytes 0x39,0x3F,0x30,0x35,0x0D,0x0A.
6. Reset mid-SEND: rst=1 after the 2nd transfer → valid_out=0, busy=0, meas_start=0 the next cycle; a fresh button press then produces a complete line.
